// File: rtl/i2c_target_mem_ctrl.sv
// I2C target bridging bus writes/reads to a single-port byte memory with an auto-incrementing pointer.
// Bus events are seen SYNC_STAGES+1 clk after the pads; memory strobes are one-clk registered pulses.
module i2c_target_mem_ctrl #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         MEM_AW      = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DEV_ADR  = 3'd1;
  localparam logic [2:0] DEV_ACK  = 3'd2;
  localparam logic [2:0] WR_BYTE  = 3'd3;
  localparam logic [2:0] WR_ACK   = 3'd4;
  localparam logic [2:0] RD_BYTE  = 3'd5;
  localparam logic [2:0] RD_ACK   = 3'd6;
  localparam logic [2:0] IGNORE   = 3'd7;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic [2:0]             state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [MEM_AW-1:0]      ptr_q, ptr_d;
  logic [MEM_AW-1:0]      addr_q, addr_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   first_q, first_d;
  logic                   ack_q, ack_d;
  logic                   load_q;
  logic                   sda_oe_q, sda_oe_d;
  logic                   we_q, we_d, re_q, re_d;
  logic                   busy_q, busy_d, done_q, done_d;

  logic       scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] rx_byte;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign start_c  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_c   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign rx_byte  = {shift_q[6:0], sda_s};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    first_d   = first_q;
    ack_d     = ack_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    done_d    = 1'b0;
    // Bus conditions pre-empt everything, so a byte cut short never reaches its commit point.
    if (start_c) begin
      state_d   = DEV_ADR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_c) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      done_d    = busy_q;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        DEV_ADR: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (rx_byte[7:1] == DEV_ADDR) begin
              state_d = DEV_ACK;
              busy_d  = 1'b1;
              ack_d   = 1'b0;
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        DEV_ACK: begin
          if (scl_fall && !ack_q) begin
            sda_oe_d = 1'b1;
            ack_d    = 1'b1;
          end else if (scl_rise && ack_q) begin
            bit_cnt_d = 3'd0;
            if (shift_q[0]) begin
              re_d    = 1'b1;
              addr_d  = ptr_q;
              state_d = RD_BYTE;
            end else begin
              first_d = 1'b1;
              state_d = WR_BYTE;
            end
          end
        end
        WR_BYTE: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = WR_ACK;
              ack_d   = 1'b0;
              if (first_q) begin
                ptr_d   = rx_byte[MEM_AW-1:0];
                first_d = 1'b0;
              end else begin
                addr_d  = ptr_q;
                wdata_d = rx_byte;
                we_d    = 1'b1;
                ptr_d   = ptr_q + 1'b1;
              end
            end
          end
        end
        WR_ACK: begin
          if (scl_fall && !ack_q) begin
            sda_oe_d = 1'b1;
            ack_d    = 1'b1;
          end else if (scl_rise && ack_q) begin
            state_d   = WR_BYTE;
            bit_cnt_d = 3'd0;
          end
        end
        RD_BYTE: begin
          // Read data lands well inside the SCL high phase, before the first falling edge.
          if (load_q) begin
            shift_d = mem_rdata;
          end else if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = RD_ACK;
          end
        end
        RD_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            if (!sda_s) begin
              ptr_d     = ptr_q + 1'b1;
              addr_d    = ptr_q + 1'b1;
              re_d      = 1'b1;
              bit_cnt_d = 3'd0;
              state_d   = RD_BYTE;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        IGNORE:  sda_oe_d = 1'b0;
        default: state_d  = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      ptr_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= 8'd0;
      first_q    <= 1'b0;
      ack_q      <= 1'b0;
      load_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      first_q    <= first_d;
      ack_q      <= ack_d;
      load_q     <= re_q;
      sda_oe_q   <= sda_oe_d;
      we_q       <= we_d;
      re_q       <= re_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_i2c_target_mem_ctrl.sv
// Bench for i2c_target_mem_ctrl: bit-banged I2C master, behavioural RAM and a byte-level memory/pointer model.
`timescale 1ns/1ps
module tb_i2c_target_mem_ctrl;
  localparam int         H    = 10;
  localparam logic [6:0] DEVA = 7'h50;

  logic       clk = 1'b0;
  logic       reset_n, scl_m, sda_m, sda_line;
  logic       sda_oe, mem_we, mem_re, busy, done;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;
  assign sda_line = sda_m & ~sda_oe;

  i2c_target_mem_ctrl #(.DEV_ADDR(DEVA), .MEM_AW(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy), .done(done)
  );

  logic [7:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // Event log of DUT strobes, appended on the falling clock edge.
  logic [7:0] we_a [0:4095];
  logic [7:0] we_v [0:4095];
  logic [7:0] re_a [0:4095];
  int we_n = 0, re_n = 0, done_n = 0, oe_n = 0, busy_n = 0, both_n = 0;
  always @(negedge clk) begin
    if (mem_we) begin
      we_a[we_n[11:0]] <= mem_addr;
      we_v[we_n[11:0]] <= mem_wdata;
      we_n <= we_n + 1;
    end
    if (mem_re) begin
      re_a[re_n[11:0]] <= mem_addr;
      re_n <= re_n + 1;
    end
    if (done)            done_n <= done_n + 1;
    if (sda_oe)          oe_n   <= oe_n + 1;
    if (busy)            busy_n <= busy_n + 1;
    if (mem_we && mem_re) both_n <= both_n + 1;
  end

  // Reference model: memory contents and pointer, tracked per byte.
  logic [7:0] ref_mem [0:255];
  logic       ref_vld [0:255];
  logic [7:0] ref_ptr;
  logic [7:0] wbuf [0:7];
  logic [7:0] rbuf [0:7];

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_x(input logic b, output logic r);
    sda_m = b; wclk(H);
    scl_m = 1'b1; wclk(H/2);
    r = sda_line; wclk(H/2);
    scl_m = 1'b0; wclk(3);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; wclk(H);
    scl_m = 1'b1; wclk(H);
    sda_m = 1'b0; wclk(H);
    scl_m = 1'b0; wclk(3);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wclk(H);
    scl_m = 1'b1; wclk(H);
    sda_m = 1'b1; wclk(H);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    logic [7:0] sh; logic r;
    sh = b;
    for (int i = 0; i < n; i++) begin
      bit_x(sh[7], r);
      sh = sh << 1;
    end
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic nak);
    send_bits(b, 8);
    bit_x(1'b1, nak);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic r;
    d = 8'd0;
    for (int i = 0; i < 8; i++) begin
      bit_x(1'b1, r);
      d = {d[6:0], r};
    end
    bit_x(mack, r);
  endtask

  task automatic write_txn(input logic [7:0] p, input int len, input string tag);
    logic nak; int we0, dn0, idx;
    we0 = we_n; dn0 = done_n;
    i2c_start;
    wr_byte({DEVA, 1'b0}, nak); chk({tag, " addr ack"}, 32'(nak), 0);
    wr_byte(p, nak);            chk({tag, " ptr ack"}, 32'(nak), 0);
    for (int i = 0; i < len; i++) begin
      wr_byte(wbuf[i[2:0]], nak); chk({tag, " data ack"}, 32'(nak), 0);
    end
    i2c_stop; wclk(4);
    chk({tag, " we count"}, 32'(we_n - we0), 32'(len));
    ref_ptr = p;
    for (int i = 0; i < len; i++) begin
      idx = we0 + i;
      chk({tag, " we addr"}, 32'(we_a[idx[11:0]]), 32'(ref_ptr));
      chk({tag, " we data"}, 32'(we_v[idx[11:0]]), 32'(wbuf[i[2:0]]));
      ref_mem[ref_ptr] = wbuf[i[2:0]];
      ref_vld[ref_ptr] = 1'b1;
      ref_ptr = ref_ptr + 8'd1;
    end
    chk({tag, " done pulses"}, 32'(done_n - dn0), 1);
  endtask

  task automatic read_txn(input logic [7:0] p, input int len, input string tag);
    logic nak; logic [7:0] d; int we0, re0, dn0, idx;
    we0 = we_n; re0 = re_n; dn0 = done_n;
    i2c_start;
    wr_byte({DEVA, 1'b0}, nak); chk({tag, " addr ack"}, 32'(nak), 0);
    wr_byte(p, nak);            chk({tag, " ptr ack"}, 32'(nak), 0);
    i2c_start;
    wr_byte({DEVA, 1'b1}, nak); chk({tag, " raddr ack"}, 32'(nak), 0);
    for (int i = 0; i < len; i++) begin
      rd_byte(i == len - 1, d);
      rbuf[i[2:0]] = d;
    end
    i2c_stop; wclk(4);
    chk({tag, " re count"}, 32'(re_n - re0), 32'(len));
    ref_ptr = p;
    for (int i = 0; i < len; i++) begin
      idx = re0 + i;
      chk({tag, " re addr"}, 32'(re_a[idx[11:0]]), 32'(ref_ptr));
      chk({tag, " rd data"}, 32'(rbuf[i[2:0]]), 32'(ref_mem[ref_ptr]));
      if (i < len - 1) ref_ptr = ref_ptr + 8'd1;
    end
    chk({tag, " no we"}, 32'(we_n - we0), 0);
    chk({tag, " done pulses"}, 32'(done_n - dn0), 1);
  endtask

  task automatic cur_read(input string tag);
    logic nak; logic [7:0] d; int re0, idx;
    re0 = re_n;
    i2c_start;
    wr_byte({DEVA, 1'b1}, nak); chk({tag, " raddr ack"}, 32'(nak), 0);
    rd_byte(1'b1, d);
    i2c_stop; wclk(4);
    idx = re0;
    chk({tag, " re count"}, 32'(re_n - re0), 1);
    chk({tag, " re addr"}, 32'(re_a[idx[11:0]]), 32'(ref_ptr));
    if (ref_vld[ref_ptr]) chk({tag, " rd data"}, 32'(d), 32'(ref_mem[ref_ptr]));
  endtask

  task automatic nack_txn(input logic [6:0] a7, input string tag);
    logic nak; int we0, re0, dn0, oe0, bz0;
    we0 = we_n; re0 = re_n; dn0 = done_n; oe0 = oe_n; bz0 = busy_n;
    i2c_start;
    wr_byte({a7, 1'b0}, nak); chk({tag, " addr nack"}, 32'(nak), 1);
    wr_byte(8'h33, nak);      chk({tag, " data nack"}, 32'(nak), 1);
    i2c_stop; wclk(4);
    chk({tag, " sda_oe idle"}, 32'(oe_n - oe0), 0);
    chk({tag, " busy idle"}, 32'(busy_n - bz0), 0);
    chk({tag, " no strobes"}, 32'((we_n - we0) + (re_n - re0)), 0);
    chk({tag, " no done"}, 32'(done_n - dn0), 0);
  endtask

  task automatic reset_recover;
    scl_m = 1'b1; sda_m = 1'b1; wclk(4);
    reset_n = 1'b1; wclk(H);
    ref_ptr = 8'd0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic nak; logic [6:0] bad; logic [7:0] p; int we0, dn0, len;
    for (int i = 0; i < 256; i++) ref_vld[i] = 1'b0;
    ref_ptr = 8'd0;
    reset_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    wclk(2);
    chk("reset sda_oe", 32'(sda_oe), 0);
    chk("reset strobes", 32'({mem_we, mem_re}), 0);
    chk("reset busy/done", 32'({busy, done}), 0);
    chk("reset mem_addr", 32'(mem_addr), 0);
    chk("reset mem_wdata", 32'(mem_wdata), 0);
    wclk(3); reset_n = 1'b1; wclk(5);

    wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
    write_txn(8'h10, 2, "t1");
    chk("t1 mem_wdata held", 32'(mem_wdata), 32'hC3);
    cur_read("t1 ptr after burst");
    chk("t1 ptr is 0x12", 32'(ref_ptr), 32'h12);

    read_txn(8'h10, 2, "t2");
    chk("t2 byte0", 32'(rbuf[0]), 32'h5A);
    chk("t2 byte1", 32'(rbuf[1]), 32'hC3);

    nack_txn(7'h51, "t3");
    do bad = 7'($urandom_range(0, 127)); while (bad == DEVA);
    nack_txn(bad, "t3 rand");

    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    write_txn(8'hFF, 2, "t4");
    chk("t4 first at 0xFF", 32'(we_a[12'(we_n - 2)]), 32'hFF);
    chk("t4 wrap to 0x00", 32'(we_a[12'(we_n - 1)]), 32'h00);

    // Reset while the DUT is actively acknowledging: SDA must be released at once.
    i2c_start;
    send_bits({DEVA, 1'b0}, 8);
    sda_m = 1'b1; wclk(H); scl_m = 1'b1; wclk(H/2);
    chk("t5 ack driven", 32'(sda_oe), 1);
    #2 reset_n = 1'b0; #1;
    chk("t5 ack released by reset", 32'(sda_oe), 0);
    reset_recover;

    we0 = we_n;
    i2c_start;
    wr_byte({DEVA, 1'b0}, nak); chk("t5 addr ack", 32'(nak), 0);
    wr_byte(8'h40, nak);        chk("t5 ptr ack", 32'(nak), 0);
    send_bits(8'hA5, 3);
    sda_m = 1'b0; wclk(H); scl_m = 1'b1; wclk(H/2);
    chk("t5 busy before reset", 32'(busy), 1);
    #2 reset_n = 1'b0; #1;
    chk("t5 sda_oe in reset", 32'(sda_oe), 0);
    chk("t5 busy in reset", 32'(busy), 0);
    chk("t5 mem_addr in reset", 32'(mem_addr), 0);
    reset_recover;
    chk("t5 no we", 32'(we_n - we0), 0);
    cur_read("t5 ptr cleared");
    wbuf[0] = 8'h9E; wbuf[1] = 8'h01;
    write_txn(8'h40, 2, "t5 after");

    for (int i = 0; i < 3; i++) wbuf[i[2:0]] = 8'($urandom_range(0, 255));
    write_txn(8'h20, 3, "t6 pre");
    we0 = we_n; dn0 = done_n;
    i2c_start;
    wr_byte({DEVA, 1'b0}, nak); chk("t6 addr ack", 32'(nak), 0);
    wr_byte(8'h20, nak);        chk("t6 ptr ack", 32'(nak), 0);
    send_bits(8'hF0, 5);
    i2c_stop; wclk(4);
    ref_ptr = 8'h20;
    chk("t6 no we", 32'(we_n - we0), 0);
    chk("t6 done", 32'(done_n - dn0), 1);
    chk("t6 idle busy", 32'(busy), 0);
    cur_read("t6 ptr unchanged");

    for (int k = 0; k < 4; k++) begin
      p   = (k == 0) ? 8'hFE : 8'($urandom_range(0, 255));
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) wbuf[i[2:0]] = 8'($urandom_range(0, 255));
      write_txn(p, len, "rnd wr");
      read_txn(p, len, "rnd rd");
    end

    chk("we/re exclusive", 32'(both_n), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
